// File: rtl/rtc_hms_counter_pkg.sv
// Shared constants, time struct and BCD helpers for the HH:MM:SS time-of-day counter.
package rtc_pkg;

    localparam int unsigned TIME_W           = 24;
    localparam logic [3:0]  BCD_MAX_SEC_TENS = 4'd5;
    localparam logic [3:0]  BCD_MAX_MIN_TENS = 4'd5;
    localparam logic [3:0]  BCD_NINE         = 4'd9;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } rtc_time_t;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= BCD_NINE;
    endfunction

    function automatic logic bcd8_ok(input logic [7:0] v);
        return is_bcd(v[7:4]) && is_bcd(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd8(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/rtc_hms_counter_if.sv
// Control, load and time/strobe bundle between the RTC counter and its driver.
interface rtc_hms_counter_if;
    import rtc_pkg::*;

    logic       sec_in;
    logic       en;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       sec_pulse;
    logic       min_pulse;
    logic       hour_pulse;
    logic       day_pulse;
    logic       load_err;

    modport master (
        output sec_in, en, load, load_hh, load_mm, load_ss,
        input  hh, mm, ss, sec_pulse, min_pulse, hour_pulse, day_pulse, load_err
    );

    modport slave (
        input  sec_in, en, load, load_hh, load_mm, load_ss,
        output hh, mm, ss, sec_pulse, min_pulse, hour_pulse, day_pulse, load_err
    );

endinterface

// File: rtl/rtc_hms_counter_bcd_digit.sv
// One BCD digit counting 0..MAX with parallel load; carry is raised combinationally on the wrapping increment.
module bcd_digit
    import rtc_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_NINE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q, q_d;

    assign carry = inc & (q_q == MAX);
    assign q     = q_q;

    always_comb begin
        q_d = q_q;
        if (load)
            q_d = ld_val;
        else if (inc)
            q_d = carry ? 4'd0 : q_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= 4'd0;
        else     q_q <= q_d;
    end

endmodule

// File: rtl/rtc_hms_counter.sv
// BCD 24-hour time-of-day counter advanced by rising edges (or strobes) of the 1 Hz divider output,
// with validated parallel set and registered rollover strobes.
module rtc_hms_counter
    import rtc_pkg::*;
#(
    parameter bit          STROBE_IN = 1'b0,
    parameter int unsigned HOUR_MAX  = 23
) (
    input  logic               clk,
    input  logic               rst,
    rtc_hms_counter_if.slave   bus
);

    localparam logic [7:0] HOUR_MAX_BCD = to_bcd8(HOUR_MAX);

    logic             sec_q;
    logic             tick, cnt;
    logic             load_valid, ld_ok, ld_bad;
    logic [3:0]       dinc, dcy;
    logic [3:0][3:0]  dq, dld;
    logic [7:0]       hh_q, hh_d;
    logic             hour_inc, hour_wrap, hh_units_wrap;
    logic             sec_pulse_q, min_pulse_q, hour_pulse_q, day_pulse_q, load_err_q;

    // Resets high so a divider output already high at reset release is not mistaken for an edge.
    always_ff @(posedge clk) begin
        if (rst) sec_q <= 1'b1;
        else     sec_q <= bus.sec_in;
    end

    assign tick = STROBE_IN ? bus.sec_in : (bus.sec_in & ~sec_q);
    assign cnt  = tick & bus.en & ~bus.load;

    assign load_valid = bcd8_ok(bus.load_hh) && bcd8_ok(bus.load_mm) && bcd8_ok(bus.load_ss)
                     && (bus.load_ss <= 8'h59) && (bus.load_mm <= 8'h59)
                     && (bus.load_hh <= HOUR_MAX_BCD);
    assign ld_ok  = bus.load & load_valid;
    assign ld_bad = bus.load & ~load_valid;

    // Digit order: 0 ss units, 1 ss tens, 2 mm units, 3 mm tens; each digit's carry feeds the next.
    assign dld  = {bus.load_mm[7:4], bus.load_mm[3:0], bus.load_ss[7:4], bus.load_ss[3:0]};
    assign dinc = {dcy[2:0], cnt};

    for (genvar k = 0; k < 4; k++) begin : g_digit
        localparam logic [3:0] DMAX = (k == 1) ? BCD_MAX_SEC_TENS :
                                      (k == 3) ? BCD_MAX_MIN_TENS : BCD_NINE;
        bcd_digit #(.MAX(DMAX)) u_digit (
            .clk    (clk),
            .rst    (rst),
            .inc    (dinc[k]),
            .load   (ld_ok),
            .ld_val (dld[k]),
            .q      (dq[k]),
            .carry  (dcy[k])
        );
    end

    // Hours units wrap at 9, or at 3 in the twenties, so this digit pair cannot reuse bcd_digit.
    assign hour_inc      = dcy[3];
    assign hour_wrap     = hour_inc & (hh_q == HOUR_MAX_BCD);
    assign hh_units_wrap = (hh_q[3:0] == BCD_NINE) || (hh_q[7:4] == 4'd2 && hh_q[3:0] == 4'd3);

    always_comb begin
        hh_d = hh_q;
        if (ld_ok)
            hh_d = bus.load_hh;
        else if (hour_wrap)
            hh_d = 8'h00;
        else if (hour_inc)
            hh_d = hh_units_wrap ? {hh_q[7:4] + 4'd1, 4'd0} : {hh_q[7:4], hh_q[3:0] + 4'd1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hh_q         <= 8'h00;
            sec_pulse_q  <= 1'b0;
            min_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
            day_pulse_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            hh_q         <= hh_d;
            sec_pulse_q  <= cnt;
            min_pulse_q  <= dcy[1];
            hour_pulse_q <= dcy[3];
            day_pulse_q  <= hour_wrap;
            load_err_q   <= ld_bad;
        end
    end

    assign bus.hh         = hh_q;
    assign bus.mm         = {dq[3], dq[2]};
    assign bus.ss         = {dq[1], dq[0]};
    assign bus.sec_pulse  = sec_pulse_q;
    assign bus.min_pulse  = min_pulse_q;
    assign bus.hour_pulse = hour_pulse_q;
    assign bus.day_pulse  = day_pulse_q;
    assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Directed bench for rtc_hms_counter: per-cycle vector table plus hand sequences for carries and long runs.
module tb_rtc_hms_counter;

    localparam logic [4:0] P0    = 5'b00000;
    localparam logic [4:0] P_SEC = 5'b10000;
    localparam logic [4:0] P_MIN = 5'b01000;
    localparam logic [4:0] P_HR  = 5'b00100;
    localparam logic [4:0] P_DAY = 5'b00010;
    localparam logic [4:0] P_ERR = 5'b00001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rtc_hms_counter_if bus();

    rtc_hms_counter #(.STROBE_IN(1'b0), .HOUR_MAX(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       r, s, e, l;
        logic [7:0] lh, lm, ls;
        logic [7:0] eh, em, es;
        logic [4:0] ep;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic r, s, e, l, input logic [7:0] lh, lm, ls,
                                input logic [7:0] eh, em, es, input logic [4:0] ep);
        vec_t v;
        v.r = r; v.s = s; v.e = e; v.l = l;
        v.lh = lh; v.lm = lm; v.ls = ls;
        v.eh = eh; v.em = em; v.es = es; v.ep = ep;
        return v;
    endfunction

    function automatic logic [28:0] obs();
        return {bus.hh, bus.mm, bus.ss, bus.sec_pulse, bus.min_pulse,
                bus.hour_pulse, bus.day_pulse, bus.load_err};
    endfunction

    task automatic check(input string nm, input logic [28:0] act, input logic [28:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h:%h:%h pulses=%b, want %h:%h:%h pulses=%b", nm,
                     act[28:21], act[20:13], act[12:5], act[4:0],
                     exp[28:21], exp[20:13], exp[12:5], exp[4:0]);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, and leave time to sample outputs.
    task automatic drive(input logic r, s, e, l, input logic [7:0] lh, lm, ls);
        rst = r; bus.sec_in = s; bus.en = e; bus.load = l;
        bus.load_hh = lh; bus.load_mm = lm; bus.load_ss = ls;
        @(posedge clk);
        #1;
    endtask

    task automatic run_edges(input int n, output int ns, output int nm, output int nh, output int nd);
        ns = 0; nm = 0; nh = 0; nd = 0;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 20; c++) begin
                drive(1'b0, (c < 10), 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
                ns += int'(bus.sec_pulse);
                nm += int'(bus.min_pulse);
                nh += int'(bus.hour_pulse);
                nd += int'(bus.day_pulse);
            end
        end
    endtask

    initial begin
        logic [7:0] hc_in[3];
        logic [7:0] hc_out[3];
        int ns, nm, nh, nd;

        rst = 1'b1; bus.sec_in = 1'b1; bus.en = 1'b1; bus.load = 1'b0;
        bus.load_hh = 8'h00; bus.load_mm = 8'h00; bus.load_ss = 8'h00;

        // reset release with sec_in high, first count only on a true rising edge
        vecs.push_back(mk(1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, P0));
        vecs.push_back(mk(1, 0, 1, 1, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, P0));
        vecs.push_back(mk(1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, P0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, P0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, P0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, P0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, P_SEC));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, P0));
        // 00:00:58 -> 59 -> 00:01:00
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h00, 8'h58, 8'h00, 8'h00, 8'h58, P0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h59, P_SEC));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h59, P0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, P_SEC | P_MIN));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, P0));
        // day rollover
        vecs.push_back(mk(0, 0, 1, 1, 8'h23, 8'h59, 8'h59, 8'h23, 8'h59, 8'h59, P0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, P_SEC | P_MIN | P_HR | P_DAY));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, P0));
        // rejected loads leave the prior time intact
        vecs.push_back(mk(0, 0, 1, 1, 8'h08, 8'h30, 8'h15, 8'h08, 8'h30, 8'h15, P0));
        vecs.push_back(mk(0, 0, 1, 1, 8'h24, 8'h00, 8'h00, 8'h08, 8'h30, 8'h15, P_ERR));
        vecs.push_back(mk(0, 0, 1, 1, 8'h12, 8'h5A, 8'h00, 8'h08, 8'h30, 8'h15, P_ERR));
        vecs.push_back(mk(0, 0, 1, 1, 8'h1A, 8'h00, 8'h00, 8'h08, 8'h30, 8'h15, P_ERR));
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h60, 8'h00, 8'h08, 8'h30, 8'h15, P_ERR));
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h00, 8'h0A, 8'h08, 8'h30, 8'h15, P_ERR));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h08, 8'h30, 8'h15, P0));
        // load coincident with a rising edge swallows that tick
        vecs.push_back(mk(0, 1, 1, 1, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30, P0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, P0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h31, P_SEC));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h31, P0));
        // frozen across five edges, then enable while sec_in is high
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h31, P0));
            vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h31, P0));
        end
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h31, P0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h31, P0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h31, P0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h32, P_SEC));
        // reset mid-count, coincident with a rising edge
        vecs.push_back(mk(0, 0, 1, 1, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, P0));
        vecs.push_back(mk(1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, P0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, P0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, P0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, P_SEC));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].e, vecs[i].l, vecs[i].lh, vecs[i].lm, vecs[i].ls);
            check($sformatf("vec%0d", i), obs(), {vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].ep});
        end

        // hour carries, including the tens step into the twenties
        hc_in[0]  = 8'h09; hc_in[1]  = 8'h19; hc_in[2]  = 8'h22;
        hc_out[0] = 8'h10; hc_out[1] = 8'h20; hc_out[2] = 8'h23;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, hc_in[i], 8'h59, 8'h59);
            drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
            check($sformatf("hour_carry%0d", i), obs(), {hc_out[i], 8'h00, 8'h00, P_SEC | P_MIN | P_HR});
        end

        // load held for three cycles across a rising edge, re-applied each cycle
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'h06, 8'h07);
        check("held_load0", obs(), {8'h05, 8'h06, 8'h07, P0});
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 8'h06, 8'h07);
        check("held_load1", obs(), {8'h05, 8'h06, 8'h07, P0});
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'h06, 8'h07);
        check("held_load2", obs(), {8'h05, 8'h06, 8'h07, P0});
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        check("held_load_after", obs(), {8'h05, 8'h06, 8'h08, P_SEC});

        // loads are accepted while frozen
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'h11, 8'h11);
        check("load_frozen", obs(), {8'h11, 8'h11, 8'h11, P0});
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        check("frozen_edge", obs(), {8'h11, 8'h11, 8'h11, P0});

        // one full minute of 20-cycle square wave
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        run_edges(60, ns, nm, nh, nd);
        check("minute_time", obs(), {8'h00, 8'h01, 8'h00, P0});
        check_int("minute_sec_pulses", ns, 60);
        check_int("minute_min_pulses", nm, 1);
        check_int("minute_hour_pulses", nh, 0);

        // last minute of the day
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h23, 8'h59, 8'h00);
        run_edges(60, ns, nm, nh, nd);
        check("day_time", obs(), {8'h00, 8'h00, 8'h00, P0});
        check_int("day_sec_pulses", ns, 60);
        check_int("day_hour_pulses", nh, 1);
        check_int("day_day_pulses", nd, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
